// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter that shares one Gray-to-binary converter among N_REQ
// requesters and returns the binary result with the requester index.
//
// state | meaning
// IDLE  | waiting for any req; picks the round-robin winner, latches its word
// CONV  | converts the latched word into the output register
// OUT   | holds the result until the consumer takes it, then advances rr
module gray_conv_arbiter #(
  parameter  int N_REQ = 4,
  parameter  int W     = 4,
  localparam int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] i,
  output logic [N_REQ-1:0]   grant,
  output logic [W-1:0]       o,
  output logic [IDW-1:0]     o_id,
  output logic               o_valid,
  input  logic               o_ready
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CONV = 2'd1;
  localparam logic [1:0] OUT  = 2'd2;

  localparam logic [IDW-1:0] LAST_ID = IDW'(N_REQ - 1);

  logic [1:0]     state;
  logic [IDW-1:0] rr;
  logic [IDW-1:0] id_q;
  logic [W-1:0]   g_q;
  logic [IDW-1:0] win;
  logic           win_ok;
  logic [W-1:0]   bin;

  function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int k = W - 2; k >= 0; k--) begin
      b[k] = b[k+1] ^ g[k];
    end
    return b;
  endfunction

  // The single shared converter always works on the latched word.
  assign bin = gray2bin(g_q);

  // Search starts at rr and wraps, so the first hit is the round-robin winner.
  always_comb begin
    win    = '0;
    win_ok = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!win_ok && req[(int'(rr) + k) % N_REQ]) begin
        win_ok = 1'b1;
        win    = IDW'((int'(rr) + k) % N_REQ);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      rr      <= '0;
      id_q    <= '0;
      g_q     <= '0;
      grant   <= '0;
      o       <= '0;
      o_id    <= '0;
      o_valid <= 1'b0;
    end else begin
      grant <= '0;
      case (state)
        IDLE: begin
          if (win_ok) begin
            g_q   <= i[win*W +: W];
            id_q  <= win;
            grant <= N_REQ'(1) << win;
            state <= CONV;
          end
        end
        CONV: begin
          o       <= bin;
          o_id    <= id_q;
          o_valid <= 1'b1;
          state   <= OUT;
        end
        OUT: begin
          if (o_valid && o_ready) begin
            o_valid <= 1'b0;
            // Explicit wrap keeps rr in range when N_REQ is not a power of two.
            rr      <= (id_q == LAST_ID) ? '0 : id_q + 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Self-checking bench for gray_conv_arbiter: vector table, scoreboard queues
// and hand-written multi-cycle sequences.
module tb_gray_conv_arbiter;
  localparam int N_REQ = 4;
  localparam int W     = 4;
  localparam int IDW   = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [N_REQ-1:0]   req = '0;
  logic [N_REQ*W-1:0] i   = '0;
  logic [N_REQ-1:0]   grant;
  logic [W-1:0]       o;
  logic [IDW-1:0]     o_id;
  logic               o_valid;
  logic               o_ready = 1'b1;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [W-1:0]   val;
  } out_t;

  typedef struct {
    int         id;
    logic [W-1:0] gray;
    logic [W-1:0] bin;
  } vec_t;

  out_t             exp_out[$];
  logic [N_REQ-1:0] exp_grant[$];
  vec_t             vecs[6];

  gray_conv_arbiter #(.N_REQ(N_REQ), .W(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .i       (i),
    .grant   (grant),
    .o       (o),
    .o_id    (o_id),
    .o_valid (o_valid),
    .o_ready (o_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] ref_bin(input logic [W-1:0] g);
    logic [W-1:0] b;
    for (int k = 0; k < W; k++) b[k] = ^(g >> k);
    return b;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_word(input int id, input logic [W-1:0] g);
    i[id*W +: W] = g;
  endtask

  task automatic expect_conv(input int id, input logic [W-1:0] bin);
    out_t e;
    e.id  = IDW'(id);
    e.val = bin;
    exp_grant.push_back(N_REQ'(1) << id);
    exp_out.push_back(e);
  endtask

  task automatic run_single(input int id, input logic [W-1:0] gray, input logic [W-1:0] bin);
    set_word(id, gray);
    req     = N_REQ'(1) << id;
    o_ready = 1'b1;
    expect_conv(id, bin);
    step();
    chk("single_grant_c1", 32'(grant), 32'(N_REQ'(1) << id));
    chk("single_valid_c1", 32'(o_valid), 0);
    req = '0;
    step();
    chk("single_valid_c2", 32'(o_valid), 1);
    chk("single_grant_c2", 32'(grant), 0);
    step();
    chk("single_valid_c3", 32'(o_valid), 0);
  endtask

  task automatic wait_grant(input string name);
    int cnt = 0;
    while (grant == '0 && cnt < 12) begin
      step();
      cnt++;
    end
    chk(name, 32'(|grant), 1);
  endtask

  // Scoreboard: sampled on the falling edge, i.e. just before the edge that acts.
  always @(negedge clk) begin
    out_t e;
    if (!rst) begin
      if (grant != '0) begin
        if (exp_grant.size() == 0) chk("grant_unexpected", 32'(grant), 0);
        else chk("grant_order", 32'(grant), 32'(exp_grant.pop_front()));
        chk("grant_valid_excl", 32'(o_valid), 0);
      end
      if (o_valid && o_ready) begin
        if (exp_out.size() == 0) begin
          chk("out_unexpected", 32'(exp_out.size()), 1);
        end else begin
          e = exp_out.pop_front();
          chk("out_value", 32'(o), 32'(e.val));
          chk("out_id", 32'(o_id), 32'(e.id));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int last;
    vecs[0] = '{0, 4'b1011, 4'b1101};
    vecs[1] = '{0, 4'b1000, 4'b1111};
    vecs[2] = '{0, 4'b0110, 4'b0100};
    vecs[3] = '{1, 4'b0001, 4'b0001};
    vecs[4] = '{2, 4'b1111, 4'b1010};
    vecs[5] = '{3, 4'b0100, 4'b0111};

    // Reset holds outputs at zero whatever the inputs do.
    for (int c = 0; c < 3; c++) begin
      req = N_REQ'($urandom);
      i   = (N_REQ*W)'($urandom);
      step();
      chk("rst_grant", 32'(grant), 0);
      chk("rst_valid", 32'(o_valid), 0);
      chk("rst_o", 32'(o), 0);
      chk("rst_o_id", 32'(o_id), 0);
    end
    req = '0;
    i   = '0;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("idle_grant", 32'(grant), 0);
      chk("idle_valid", 32'(o_valid), 0);
    end

    for (int t = 0; t < 6; t++) run_single(vecs[t].id, vecs[t].gray, vecs[t].bin);

    // All four requesting at once, rr starts at 0.
    set_word(0, 4'b0011);
    set_word(1, 4'b0101);
    set_word(2, 4'b1100);
    set_word(3, 4'b1110);
    for (int k = 0; k < 4; k++) expect_conv(k, ref_bin(i[k*W +: W]));
    req  = 4'b1111;
    last = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      wait_grant("all4_grant_seen");
      chk("all4_grant", 32'(grant), 32'(N_REQ'(1) << k));
      if (k > 0) chk("all4_spacing", 32'(cyc - last), 3);
      last = cyc;
      req  = req & ~grant;
    end
    repeat (3) step();

    // Fairness: 0 and 2 keep requesting.
    set_word(0, 4'b1001);
    set_word(2, 4'b0111);
    for (int k = 0; k < 6; k++) expect_conv((k % 2 == 0) ? 0 : 2, ref_bin((k % 2 == 0) ? 4'b1001 : 4'b0111));
    req = 4'b0101;
    for (int k = 0; k < 6; k++) begin
      step();
      wait_grant("fair_grant_seen");
      chk("fair_grant", 32'(grant), (k % 2 == 0) ? 32'd1 : 32'd4);
      if (k == 5) req = '0;
    end
    repeat (3) step();

    // Backpressure: result held five cycles, next request waits for acceptance.
    o_ready = 1'b0;
    set_word(1, 4'b0011);
    set_word(3, 4'b1101);
    req = 4'b0010;
    expect_conv(1, 4'b0010);
    step();
    chk("bp_grant_c1", 32'(grant), 32'b0010);
    req = 4'b1000;
    expect_conv(3, 4'b1001);
    step();
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid_hold", 32'(o_valid), 1);
      chk("bp_o_hold", 32'(o), 32'b0010);
      chk("bp_id_hold", 32'(o_id), 1);
      chk("bp_no_grant", 32'(grant), 0);
      if (c == 4) o_ready = 1'b1;
      step();
    end
    chk("bp_valid_after", 32'(o_valid), 0);
    chk("bp_grant_after", 32'(grant), 0);
    step();
    chk("bp_next_grant", 32'(grant), 32'b1000);
    req = '0;
    repeat (2) step();

    // Reset mid-operation: move rr to 2 first, then reset during OUT.
    run_single(1, 4'b0010, ref_bin(4'b0010));
    o_ready = 1'b0;
    set_word(1, 4'b0111);
    set_word(3, 4'b1010);
    req = 4'b1010;
    exp_grant.push_back(4'b1000);
    step();
    chk("mr_grant", 32'(grant), 32'b1000);
    step();
    chk("mr_valid_before", 32'(o_valid), 1);
    rst = 1'b1;
    #1;
    chk("mr_o", 32'(o), 0);
    chk("mr_id", 32'(o_id), 0);
    chk("mr_valid", 32'(o_valid), 0);
    chk("mr_grant_clr", 32'(grant), 0);
    exp_out.delete();
    step();
    step();
    o_ready = 1'b1;
    rst     = 1'b0;
    expect_conv(1, 4'b0101);
    step();
    chk("mr_rearb_grant", 32'(grant), 32'b0010);
    req = '0;
    repeat (2) step();

    // Every Gray code through requester 3.
    for (int g = 0; g < 16; g++) run_single(3, 4'(g), ref_bin(4'(g)));

    step();
    chk("queues_drained", 32'(exp_out.size() + exp_grant.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
